mvu_sched: RTL

Job scheduler for one MVU bit-serial multiply lane. It accepts a job descriptor over a valid/ready handshake: precisions, weight and data base addresses, and tile count. It sequences the zig-zag address generation unit (`zigzagu`) through every bit-plane pair of every tile. It emits registered weight/data read addresses with accumulator control (shift, tile-last), honours datapath backpressure, and pulses `done` when the job retires. It sits between the MVU command front-end and the `zigzagu` + shift-accumulator datapath, one instance per lane.

---
 rtl/mvu_pkg.sv | 15 +
 rtl/mvu_sched.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mvu_pkg.sv
// Shared MVU lane definitions: default widths used by the scheduler, zigzagu
// and the shift-accumulator, plus the scheduler state encoding.
package mvu_pkg;

  localparam int MVU_BWADDR = 21;
  localparam int MVU_BPREC  = 4;
  localparam int MVU_BLEN   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mvu_sched_state_t;

endpackage

// File: rtl/mvu_sched.sv
// Per-lane MVU job scheduler: accepts a descriptor, steps zigzagu over every
// bit-plane pair of every tile and issues registered read addresses.
module mvu_sched
  import mvu_pkg::*;
#(
  parameter int BWADDR = MVU_BWADDR,
  parameter int BPREC  = MVU_BPREC,
  parameter int BLEN   = MVU_BLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [BPREC-1:0]  cmd_pw,
  input  logic [BPREC-1:0]  cmd_pd,
  input  logic [BWADDR-1:0] cmd_wbase,
  input  logic [BWADDR-1:0] cmd_dbase,
  input  logic [BLEN-1:0]   cmd_len,
  input  logic              stall,
  output logic              zz_clr,
  output logic              zz_step,
  output logic [BPREC-1:0]  zz_pw,
  output logic [BPREC-1:0]  zz_pd,
  input  logic              zz_sh,
  input  logic [BPREC-1:0]  zz_offw,
  input  logic [BPREC-1:0]  zz_offd,
  output logic              rd_en,
  output logic [BWADDR-1:0] waddr,
  output logic [BWADDR-1:0] daddr,
  output logic              acc_sh,
  output logic              acc_last,
  output logic              busy,
  output logic              done
);

  localparam int NPW = 2 * BPREC;
  localparam logic [NPW-1:0]  PAIR_ONE = NPW'(1);
  localparam logic [BLEN-1:0] TILE_ONE = BLEN'(1);

  mvu_sched_state_t  state_q;
  logic [BPREC-1:0]  pw_q, pd_q;
  logic [BLEN-1:0]   len_q, tc_q;
  logic [NPW-1:0]    npairs_q, pc_q;
  logic [BWADDR-1:0] wtile_q, dtile_q;
  logic [BWADDR-1:0] waddr_q, daddr_q;
  logic              rd_en_q, acc_sh_q, acc_last_q;

  logic              issue, last_pair, last_tile, degenerate;
  logic [NPW-1:0]    npairs_d;
  logic [BWADDR-1:0] waddr_d, daddr_d;

  assign issue      = (state_q == RUN) && !stall;
  assign last_pair  = (pc_q == npairs_q - PAIR_ONE);
  assign last_tile  = (tc_q == len_q - TILE_ONE);
  assign degenerate = (cmd_pw == '0) || (cmd_pd == '0) || (cmd_len == '0);
  assign npairs_d   = NPW'(cmd_pw) * NPW'(cmd_pd);
  assign waddr_d    = wtile_q + BWADDR'(zz_offw);
  assign daddr_d    = dtile_q + BWADDR'(zz_offd);

  // zz_step is combinational so a stall freezes the generator in the same cycle.
  assign cmd_ready = (state_q == IDLE);
  assign zz_clr    = (state_q == IDLE);
  assign zz_step   = issue;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign zz_pw     = pw_q;
  assign zz_pd     = pd_q;
  assign rd_en     = rd_en_q;
  assign waddr     = waddr_q;
  assign daddr     = daddr_q;
  assign acc_sh    = acc_sh_q;
  assign acc_last  = acc_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pw_q       <= '0;
      pd_q       <= '0;
      len_q      <= '0;
      tc_q       <= '0;
      npairs_q   <= '0;
      pc_q       <= '0;
      wtile_q    <= '0;
      dtile_q    <= '0;
      waddr_q    <= '0;
      daddr_q    <= '0;
      rd_en_q    <= 1'b0;
      acc_sh_q   <= 1'b0;
      acc_last_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rd_en_q <= 1'b0;
          if (cmd_valid) begin
            pw_q     <= cmd_pw;
            pd_q     <= cmd_pd;
            len_q    <= cmd_len;
            npairs_q <= npairs_d;
            pc_q     <= '0;
            tc_q     <= '0;
            wtile_q  <= cmd_wbase;
            dtile_q  <= cmd_dbase;
            state_q  <= degenerate ? DONE : RUN;
          end
        end
        RUN: begin
          rd_en_q <= !stall;
          if (!stall) begin
            waddr_q    <= waddr_d;
            daddr_q    <= daddr_d;
            acc_sh_q   <= zz_sh;
            acc_last_q <= last_pair;
            // zigzagu wraps to (0,0) on this same step, so only the tile bases move.
            if (last_pair) begin
              pc_q    <= '0;
              tc_q    <= tc_q + TILE_ONE;
              wtile_q <= wtile_q + BWADDR'(pw_q);
              dtile_q <= dtile_q + BWADDR'(pd_q);
              if (last_tile) state_q <= DONE;
            end else begin
              pc_q <= pc_q + PAIR_ONE;
            end
          end
        end
        DONE: begin
          rd_en_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
